// File: rtl/pipe_ctrl.sv
// Pipeline control sequencer: turns hazard, redirect, memory-wait and halt events into
// pipeline-register enables/flushes, halt status and watchdog errors. Optional PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl #(
   parameter int STALL_MAX   = 3,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hz_stall,
   input  logic        br_taken_ex,
   input  logic        jmp_id,
   input  logic        dmem_busy,
   input  logic        halt_wb,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        pipe_freeze,
   output logic        halted,
   output logic        err,
   output logic [1:0]  err_code
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_cyc,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   localparam int SCW = $clog2(STALL_MAX + 2);
   localparam int MCW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, ERROR} state_t;

   state_t           state_q, state_d;
   logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;
   logic [MCW-1:0]   mem_cnt_q, mem_cnt_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             freeze;
   logic             resolve;
   logic             bubble;

   // Next-state and zero-latency output decode; the redirect/stall priority list is
   // shared by RUN and by the cycle in which a memory wait ends.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      mem_cnt_d   = mem_cnt_q;
      err_code_d  = err_code_q;
      freeze      = 1'b0;
      resolve     = 1'b0;
      bubble      = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pipe_freeze = 1'b0;
      halted      = 1'b0;
      err         = 1'b0;
      err_code    = 2'b00;

      unique case (state_q)
         RUN: begin
            if (halt_wb) begin
               freeze      = 1'b1;
               state_d     = HALT;
               stall_cnt_d = '0;
            end else if (dmem_busy) begin
               freeze      = 1'b1;
               state_d     = MEM_WAIT;
               mem_cnt_d   = MCW'(1);
               stall_cnt_d = '0;
            end else begin
               resolve = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_busy) begin
               freeze = 1'b1;
               if (mem_cnt_q >= MCW'(MEM_TIMEOUT)) begin
                  state_d    = ERROR;
                  err_code_d = 2'b10;
               end else begin
                  mem_cnt_d = mem_cnt_q + MCW'(1);
               end
            end else begin
               resolve   = 1'b1;
               state_d   = RUN;
               mem_cnt_d = '0;
            end
         end
         HALT: begin
            freeze = 1'b1;
            halted = 1'b1;
         end
         ERROR: begin
            freeze   = 1'b1;
            halted   = 1'b1;
            err      = 1'b1;
            err_code = err_code_q;
         end
         default: begin
            freeze = 1'b1;
         end
      endcase

      if (freeze) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
      end

      // A taken branch outranks a hazard stall: ID holds a wrong-path instruction anyway.
      if (resolve) begin
         if (br_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            stall_cnt_d = '0;
         end else if (hz_stall) begin
            bubble      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end else if (jmp_id) begin
            if_id_flush = 1'b1;
            stall_cnt_d = '0;
         end else begin
            stall_cnt_d = '0;
         end
      end

      if (bubble) begin
         if (stall_cnt_q >= SCW'(STALL_MAX)) begin
            state_d    = ERROR;
            err_code_d = 2'b01;
         end else begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
         end
      end

      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         pipe_freeze = 1'b0;
         halted      = 1'b0;
         err         = 1'b0;
         err_code    = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         mem_cnt_q   <= '0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         mem_cnt_q   <= mem_cnt_d;
         err_code_q  <= err_code_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Free-running event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_cyc   <= '0;
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (state_q == RUN || state_q == MEM_WAIT) perf_cyc <= perf_cyc + 32'd1;
         if (bubble) perf_stall <= perf_stall + 32'd1;
         if (if_id_flush) perf_flush <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level behavioural model checked every negedge,
// plus hand-computed directed expectations. Perf counters are checked when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

   localparam int STALL_MAX   = 3;
   localparam int MEM_TIMEOUT = 16;

   localparam int M_RUN  = 0;
   localparam int M_WAIT = 1;
   localparam int M_HALT = 2;
   localparam int M_ERR  = 3;

   typedef struct packed {
      logic       pc_write;
      logic       if_id_write;
      logic       if_id_flush;
      logic       id_ex_flush;
      logic       pipe_freeze;
      logic       halted;
      logic       err;
      logic [1:0] err_code;
   } outs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic hz_stall = 1'b0, br_taken_ex = 1'b0, jmp_id = 1'b0, dmem_busy = 1'b0, halt_wb = 1'b0;
   logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, halted, err;
   logic [1:0] err_code;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_cyc, perf_stall, perf_flush;
`endif

   int errors = 0;
   int checks = 0;

   int          m_mode = M_RUN;
   int          m_stalls = 0;
   int          m_busy = 0;
   logic [1:0]  m_code = 2'b00;
   logic [31:0] p_cyc = 0, p_stall = 0, p_flush = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(.STALL_MAX(STALL_MAX), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .hz_stall(hz_stall), .br_taken_ex(br_taken_ex),
      .jmp_id(jmp_id), .dmem_busy(dmem_busy), .halt_wb(halt_wb),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .halted(halted),
      .err(err), .err_code(err_code)
`ifdef PIPE_CTRL_PERF_EN
      , .perf_cyc(perf_cyc), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
   );

   // Is the pipeline frozen this cycle (memory wait just starting/continuing, or a halt retiring)?
   function automatic bit model_frozen();
      return (m_mode == M_RUN && (halt_wb || dmem_busy)) || (m_mode == M_WAIT && dmem_busy);
   endfunction

   function automatic bit model_bubble();
      return !reset && (m_mode == M_RUN || m_mode == M_WAIT) && !model_frozen()
             && !br_taken_ex && hz_stall;
   endfunction

   function automatic outs_t model_outs();
      outs_t o;
      o = '0;
      if (reset) begin
         o.if_id_flush = 1'b1;
         o.id_ex_flush = 1'b1;
      end else if (m_mode == M_HALT || m_mode == M_ERR) begin
         o.pipe_freeze = 1'b1;
         o.halted      = 1'b1;
         o.err         = (m_mode == M_ERR);
         o.err_code    = (m_mode == M_ERR) ? m_code : 2'b00;
      end else if (model_frozen()) begin
         o.pipe_freeze = 1'b1;
      end else begin
         o.pc_write    = 1'b1;
         o.if_id_write = 1'b1;
         if (br_taken_ex) begin
            o.if_id_flush = 1'b1;
            o.id_ex_flush = 1'b1;
         end else if (hz_stall) begin
            o.pc_write    = 1'b0;
            o.if_id_write = 1'b0;
            o.id_ex_flush = 1'b1;
         end else if (jmp_id) begin
            o.if_id_flush = 1'b1;
         end
      end
      return o;
   endfunction

   task automatic settle_redirects();
      if (br_taken_ex) begin
         m_stalls = 0;
      end else if (hz_stall) begin
         m_stalls++;
         if (m_stalls > STALL_MAX) begin
            m_mode = M_ERR;
            m_code = 2'b01;
         end
      end else begin
         m_stalls = 0;
      end
   endtask

   // Model advance at each edge, from the inputs held across that edge.
   always @(posedge clk) begin
      outs_t e;
      bit    bub;
      e   = model_outs();
      bub = model_bubble();
      if (reset) begin
         m_mode = M_RUN; m_stalls = 0; m_busy = 0; m_code = 2'b00;
         p_cyc = 0; p_stall = 0; p_flush = 0;
      end else begin
         if (m_mode == M_RUN || m_mode == M_WAIT) p_cyc++;
         if (bub) p_stall++;
         if (e.if_id_flush) p_flush++;
         if (m_mode == M_RUN) begin
            if (halt_wb) m_mode = M_HALT;
            else if (dmem_busy) begin
               m_mode = M_WAIT; m_busy = 1; m_stalls = 0;
            end else settle_redirects();
         end else if (m_mode == M_WAIT) begin
            if (dmem_busy) begin
               m_busy++;
               if (m_busy > MEM_TIMEOUT) begin
                  m_mode = M_ERR;
                  m_code = 2'b10;
               end
            end else begin
               m_mode = M_RUN;
               m_busy = 0;
               settle_redirects();
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      outs_t e, a;
      e = model_outs();
      a = '{pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, halted, err, err_code};
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL model_outs t=%0t: got %b expected %b", $time, a, e);
      end
`ifdef PIPE_CTRL_PERF_EN
      checks++;
      if (perf_cyc !== p_cyc || perf_stall !== p_stall || perf_flush !== p_flush) begin
         errors++;
         $display("[TB] FAIL model_perf t=%0t: got %0d/%0d/%0d expected %0d/%0d/%0d", $time,
                  perf_cyc, perf_stall, perf_flush, p_cyc, p_stall, p_flush);
      end
`endif
   end

   task automatic applyStimulus(input logic rst, input logic hz, input logic br,
                                input logic jmp, input logic busy, input logic hlt);
      @(posedge clk);
      #1;
      reset = rst; hz_stall = hz; br_taken_ex = br; jmp_id = jmp; dmem_busy = busy; halt_wb = hlt;
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic busy_cycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1, 0);
   endtask

   task automatic stall_cycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("reset_pc_write", pc_write, 0);
      checkOutput("reset_if_id_flush", if_id_flush, 1);
      checkOutput("reset_id_ex_flush", id_ex_flush, 1);
      idle(1);
      checkOutput("post_reset_pc_write", pc_write, 1);
      checkOutput("post_reset_if_id_write", if_id_write, 1);
      checkOutput("post_reset_flushes", {if_id_flush, id_ex_flush}, 0);

      stall_cycles(3);
      checkOutput("stall3_pc_write", pc_write, 0);
      checkOutput("stall3_id_ex_flush", id_ex_flush, 1);
      idle(1);
      checkOutput("stall3_resume", pc_write, 1);
      checkOutput("stall3_no_err", err, 0);

      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput("jump_flush", {pc_write, if_id_flush, id_ex_flush}, 3'b110);

      stall_cycles(3);
      applyStimulus(0, 1, 1, 0, 0, 0);
      checkOutput("branch_beats_stall", {pc_write, if_id_flush, id_ex_flush}, 3'b111);
      stall_cycles(3);
      idle(1);
      checkOutput("branch_clears_stall_cnt", err, 0);

      busy_cycles(5);
      checkOutput("busy5_freeze", {pipe_freeze, pc_write}, 2'b10);
      idle(1);
      checkOutput("busy5_resume", {pipe_freeze, pc_write}, 2'b01);

      applyStimulus(0, 0, 1, 0, 1, 0);
      applyStimulus(0, 0, 1, 0, 1, 1);
      applyStimulus(0, 0, 1, 0, 1, 0);
      checkOutput("busy_beats_branch", {pipe_freeze, if_id_flush}, 2'b10);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("branch_reapplied", {pipe_freeze, if_id_flush, id_ex_flush}, 3'b011);
      idle(1);
      checkOutput("halt_ignored_in_wait", halted, 0);

      busy_cycles(16);
      idle(1);
      checkOutput("busy16_tolerated", {err, pc_write}, 2'b01);

      stall_cycles(4);
      idle(1);
      checkOutput("stall4_err", err, 1);
      checkOutput("stall4_err_code", err_code, 2'b01);
      idle(2);
      checkOutput("stall4_err_sticky", {err, halted, pipe_freeze}, 3'b111);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle(1);
      checkOutput("err_cleared_by_reset", {err, err_code}, 3'b000);

      busy_cycles(17);
      idle(1);
      checkOutput("busy17_err_code", err_code, 2'b10);

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      idle(1);
      checkOutput("halt_next_cycle", halted, 1);
      idle(3);
      checkOutput("halt_sticky", {halted, pc_write}, 2'b10);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle(1);
      checkOutput("halt_cleared", halted, 0);
`ifdef PIPE_CTRL_PERF_EN
      checkOutput("perf_cyc_cleared", perf_cyc, 0);
`endif

      busy_cycles(7);
      applyStimulus(1, 0, 0, 0, 0, 0);
      idle(1);
      checkOutput("reset_in_wait_run", {pipe_freeze, pc_write}, 2'b01);
      busy_cycles(16);
      idle(1);
      checkOutput("reset_cleared_mem_cnt", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
